// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side instruction stream and execute-side decoded bundle
interface decode_stage_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic        out_alt;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_alt, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_alt, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32E decode stage with registered 2-entry skid buffer
module decode_stage #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  decode_stage_if.slave          bus,
  output logic [COUNT_WIDTH-1:0] illegal_count
);

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  logic [31:0] w_inst;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [3:0]  w_cls;
  logic [31:0] w_imm;
  logic        w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_bad;
  bundle_t     w_dec;
  logic        w_accept;
  logic        w_xfer;

  bundle_t              r_out;
  bundle_t              r_skid;
  logic                 r_out_valid;
  logic                 r_skid_valid;
  logic [COUNT_WIDTH-1:0] r_illegal_count;

  assign w_inst   = bus.in_data;
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];
  assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u  = {w_inst[31:12], 12'h000};
  assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  always_comb begin
    w_cls     = CLS_ILLEGAL;
    w_imm     = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_bad     = 1'b0;
    case (w_inst[6:0])
      7'b0010011: begin
        w_cls = 4'd0; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        if (w_funct3 == 3'd1 && w_funct7 != 7'h00) w_bad = 1'b1;
        if (w_funct3 == 3'd5 && w_funct7 != 7'h00 && w_funct7 != 7'h20) w_bad = 1'b1;
      end
      7'b0110011: begin
        w_cls = 4'd1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        if (w_funct7 != 7'h00 && w_funct7 != 7'h20) w_bad = 1'b1;
        if (w_funct7 == 7'h20 && w_funct3 != 3'd0 && w_funct3 != 3'd5) w_bad = 1'b1;
      end
      7'b0110111: begin w_cls = 4'd2; w_imm = w_imm_u; w_use_rd = 1'b1; end
      7'b0010111: begin w_cls = 4'd3; w_imm = w_imm_u; w_use_rd = 1'b1; end
      7'b1101111: begin w_cls = 4'd4; w_imm = w_imm_j; w_use_rd = 1'b1; end
      7'b1100111: begin
        w_cls = 4'd5; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        if (w_funct3 != 3'd0) w_bad = 1'b1;
      end
      7'b1100011: begin
        w_cls = 4'd6; w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        if (w_funct3 == 3'd2 || w_funct3 == 3'd3) w_bad = 1'b1;
      end
      7'b0000011: begin
        w_cls = 4'd7; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7) w_bad = 1'b1;
      end
      7'b0100011: begin
        w_cls = 4'd8; w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        if (w_funct3 > 3'd2) w_bad = 1'b1;
      end
      7'b1110011: begin w_cls = 4'd9; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      7'b0001111: w_cls = 4'd10;
      default:    w_bad = 1'b1;
    endcase
    // RV32E has only x0-x15, so bit 4 of any referenced register index is illegal
    if ((w_use_rd && w_inst[11]) || (w_use_rs1 && w_inst[19]) || (w_use_rs2 && w_inst[24]))
      w_bad = 1'b1;
    if (w_inst[1:0] != 2'b11) w_bad = 1'b1;
  end

  always_comb begin
    w_dec = '0;
    if (w_bad) begin
      w_dec.cls     = CLS_ILLEGAL;
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.cls    = w_cls;
      w_dec.rd     = w_use_rd  ? w_inst[10:7]  : 4'd0;
      w_dec.rs1    = w_use_rs1 ? w_inst[18:15] : 4'd0;
      w_dec.rs2    = w_use_rs2 ? w_inst[23:20] : 4'd0;
      w_dec.funct3 = w_funct3;
      w_dec.alt    = (w_cls == 4'd0 || w_cls == 4'd1) ? w_inst[30] : 1'b0;
      w_dec.imm    = w_imm;
    end
  end

  assign w_accept = bus.in_valid && !r_skid_valid && !flush;
  assign w_xfer   = r_out_valid && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out           <= '0;
      r_skid          <= '0;
      r_out_valid     <= 1'b0;
      r_skid_valid    <= 1'b0;
      r_illegal_count <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      // accept is impossible while the skid is full, so it never collides with a skid drain
      if (w_accept) begin
        if (!r_out_valid || w_xfer) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_skid       <= w_dec;
          r_skid_valid <= 1'b1;
        end
      end
      if (w_accept && w_dec.illegal && (r_illegal_count != {COUNT_WIDTH{1'b1}}))
        r_illegal_count <= r_illegal_count + 1'b1;
    end
  end

  assign bus.in_ready    = !r_skid_valid;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_class   = r_out.cls;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_rs2     = r_out.rs2;
  assign bus.out_funct3  = r_out.funct3;
  assign bus.out_alt     = r_out.alt;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_illegal = r_out.illegal;
  assign illegal_count   = r_illegal_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against an arithmetic reference model
module tb_decode_stage;

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] illegal_count;

  decode_stage_if bus();

  decode_stage #(.COUNT_WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .illegal_count (illegal_count)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q[$];
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t       e;
    int         cls, imm;
    bit         urd, urs1, urs2, bad;
    byte        fmt;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12]; f7 = w[31:25];
    urd = 0; urs1 = 0; urs2 = 0; bad = 0; fmt = "N"; cls = 15; imm = 0;
    case (w[6:0])
      7'h13: begin cls = 0;  fmt = "I"; urd = 1; urs1 = 1;
                   bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20})); end
      7'h33: begin cls = 1;  urd = 1; urs1 = 1; urs2 = 1;
                   bad = !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})); end
      7'h37: begin cls = 2;  fmt = "U"; urd = 1; end
      7'h17: begin cls = 3;  fmt = "U"; urd = 1; end
      7'h6F: begin cls = 4;  fmt = "J"; urd = 1; end
      7'h67: begin cls = 5;  fmt = "I"; urd = 1; urs1 = 1; bad = (f3 != 0); end
      7'h63: begin cls = 6;  fmt = "B"; urs1 = 1; urs2 = 1; bad = f3 inside {3'd2, 3'd3}; end
      7'h03: begin cls = 7;  fmt = "I"; urd = 1; urs1 = 1; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h23: begin cls = 8;  fmt = "S"; urs1 = 1; urs2 = 1; bad = (f3 > 2); end
      7'h73: begin cls = 9;  fmt = "I"; urd = 1; urs1 = 1; end
      7'h0F: begin cls = 10; end
      default: bad = 1;
    endcase
    if (w[1:0] != 2'b11) bad = 1;
    if ((urd && w[11]) || (urs1 && w[19]) || (urs2 && w[24])) bad = 1;
    case (fmt)
      "I": imm = $signed(w) >>> 20;
      "S": imm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      "B": imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      "U": imm = int'(w & 32'hFFFFF000);
      "J": imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default: imm = 0;
    endcase
    e = '0;
    if (bad) begin
      e.cls = 4'd15;
      e.ill = 1'b1;
    end else begin
      e.cls = 4'(cls);
      e.rd  = urd  ? w[10:7]  : 4'd0;
      e.rs1 = urs1 ? w[18:15] : 4'd0;
      e.rs2 = urs2 ? w[23:20] : 4'd0;
      e.f3  = f3;
      e.alt = (cls <= 1) ? w[30] : 1'b0;
      e.imm = imm;
    end
    return e;
  endfunction

  function automatic logic [6:0] opcode_at(input int k);
    case (k)
      0: return 7'h13;  1: return 7'h33;  2: return 7'h37;  3: return 7'h17;
      4: return 7'h6F;  5: return 7'h67;  6: return 7'h63;  7: return 7'h03;
      8: return 7'h23;  9: return 7'h73;  default: return 7'h0F;
    endcase
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) return w;
    w[6:0] = opcode_at($urandom_range(0, 10));
    if (k < 6) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (k < 8) begin w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0; end
    return w;
  endfunction

  function automatic exp_t dut_bundle();
    exp_t a;
    a.cls = bus.out_class; a.rd = bus.out_rd; a.rs1 = bus.out_rs1; a.rs2 = bus.out_rs2;
    a.f3 = bus.out_funct3; a.alt = bus.out_alt; a.imm = bus.out_imm; a.ill = bus.out_illegal;
    return a;
  endfunction

  task automatic send(input logic [31:0] w);
    int   t;
    exp_t e;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 for word 0x%08h", w);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(w);
    q.push_back(e);
    if (e.ill && exp_cnt != 16'hFFFF) exp_cnt++;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin : monitor
    exp_t act, held, e;
    bit   stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        stalled = 0;
      end else begin
        act = dut_bundle();
        if (stalled && bus.out_valid) chk("hold_stable", 64'(act), 64'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_bundle: got 0x%0h with empty scoreboard at %0t", act, $time);
          end else begin
            e = q.pop_front();
            chk("bundle", 64'(act), 64'(e));
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        held = act;
      end
    end
  end

  initial begin : stimulus
    int guard;
    bit rand_on;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(illegal_count), 64'd0);
    chk("rst_payload", 64'(dut_bundle()), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    send(32'h00500093);
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_class", 64'(bus.out_class), 64'd0);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);
    chk("addi_rs1", 64'(bus.out_rs1), 64'd0);
    chk("addi_imm", 64'(bus.out_imm), 64'd5);
    chk("addi_illegal", 64'(bus.out_illegal), 64'd0);
    @(posedge clock); #1;

    bus.out_ready = 1'b0;
    send(32'h002081B3);
    send(32'hFFF00113);
    chk("skid_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_add_class", 64'(bus.out_class), 64'd1);
    chk("stall_add_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'h312);
    chk("stall_add_imm", 64'(bus.out_imm), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk("second_class", 64'(bus.out_class), 64'd0);
    chk("second_rd", 64'(bus.out_rd), 64'd2);
    chk("second_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    chk("in_ready_back", 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;
    chk("drained_valid", 64'(bus.out_valid), 64'd0);

    send(32'hFE208EE3);
    chk("beq_class", 64'(bus.out_class), 64'd6);
    chk("beq_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'h012);
    chk("beq_imm", 64'(bus.out_imm), 64'hFFFFFFFC);
    send(32'h0080006F);
    chk("jal_class", 64'(bus.out_class), 64'd4);
    chk("jal_rd", 64'(bus.out_rd), 64'd0);
    chk("jal_imm", 64'(bus.out_imm), 64'd8);
    @(posedge clock); #1;

    bus.out_ready = 1'b0;
    send(32'h00500093);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000813;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("flush1_valid", 64'(bus.out_valid), 64'd0);
    chk("flush1_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush1_count", 64'(illegal_count), 64'd0);
    send(32'h002081B3);
    send(32'hFFF00113);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00700313;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("flush2_valid", 64'(bus.out_valid), 64'd0);
    chk("flush2_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("flush2_quiet", 64'(bus.out_valid), 64'd0);

    send(32'h00000813);
    chk("ill_class", 64'(bus.out_class), 64'd15);
    chk("ill_flag", 64'(bus.out_illegal), 64'd1);
    chk("ill_fields", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_alt}), 64'd0);
    chk("ill_imm", 64'(bus.out_imm), 64'd0);
    chk("ill_count1", 64'(illegal_count), 64'd1);

    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
          end
          send(gen_word());
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clock); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("rand_drain");
    chk("rand_count", 64'(illegal_count), 64'(exp_cnt));

    guard = 0;
    while (exp_cnt != 16'hFFFE && guard < 70000) begin
      send(32'h00000813);
      guard++;
    end
    chk("count_fffe", 64'(illegal_count), 64'hFFFE);
    repeat (3) send(32'h00000813);
    chk("count_sat", 64'(illegal_count), 64'hFFFF);
    drain("sat_drain");

    bus.out_ready = 1'b0;
    send(32'h00500093);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_count", 64'(illegal_count), 64'd0);
    chk("async_payload", 64'(dut_bundle()), 64'd0);
    q.delete();
    exp_cnt = 16'd0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_reset_count", 64'(illegal_count), 64'd0);
    bus.out_ready = 1'b1;
    send(32'h0FF00093);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
